// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input synchronise/debounce, RUN/PAUSED/ADJ mode FSM,
// tick-to-strobe gating and display blink. Optional lap freeze is built when LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int              DB_W      = 20,
    parameter logic [DB_W-1:0] DB_CYCLES = 20'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_lap,
    output logic       count_en,
    output logic       adj_sec_en,
    output logic       adj_min_en,
    output logic       blink_sec,
    output logic       blink_min,
    output logic [1:0] mode,
    output logic       freeze
);

    typedef enum logic [1:0] {
        MODE_RUN    = 2'b00,
        MODE_PAUSED = 2'b01,
        MODE_ADJ    = 2'b10
    } mode_e;

`ifdef LAP_EN
    localparam int NIN = 4;
`else
    localparam int NIN = 3;
`endif

    localparam logic [DB_W-1:0] DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
    localparam logic [DB_W-1:0] DB_LAST = DB_CYCLES - DB_ONE;

    // Input order: 0 pause, 1 adjust, 2 select, 3 lap
    logic [NIN-1:0] raw_s;
    logic [NIN-1:0] db_s;
    logic [NIN-1:0] flip_s;

`ifdef LAP_EN
    assign raw_s = {btn_lap, sw_sel, sw_adj, btn_pause};
`else
    assign raw_s = {sw_sel, sw_adj, btn_pause};
    logic lap_unused_s;
    assign lap_unused_s = btn_lap;
`endif

    for (genvar i = 0; i < NIN; i++) begin : g_db
        logic            sync1_r;
        logic            sync2_r;
        logic            db_r;
        logic [DB_W-1:0] cnt_r;

        // Two-flop synchroniser followed by a stability counter
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
                db_r    <= 1'b0;
                cnt_r   <= {DB_W{1'b0}};
            end else begin
                sync1_r <= raw_s[i];
                sync2_r <= sync1_r;
                if (sync2_r == db_r) begin
                    cnt_r <= {DB_W{1'b0}};
                end else if (cnt_r == DB_LAST) begin
                    db_r  <= sync2_r;
                    cnt_r <= {DB_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + DB_ONE;
                end
            end
        end

        // flip marks the cycle whose clock edge changes the debounced level
        assign flip_s[i] = (sync2_r != db_r) && (cnt_r == DB_LAST);
        assign db_s[i]   = db_r;
    end

    logic  pause_evt_s;
    logic  adj_db_s;
    logic  adj_db_nxt_s;
    logic  sel_db_s;
    logic  sel_db_nxt_s;
    mode_e mode_r;
    mode_e mode_nxt_s;
    logic  run_flag_r;
    logic  run_flag_nxt_s;
    logic  blink_ph_r;
    logic  blink_ph_nxt_s;
    logic  rst_done_r;
    logic  count_en_r;
    logic  adj_sec_r;
    logic  adj_min_r;
    logic  blink_sec_r;
    logic  blink_min_r;

    assign pause_evt_s  = flip_s[0] & ~db_s[0];
    assign adj_db_s     = db_s[1];
    assign adj_db_nxt_s = db_s[1] ^ flip_s[1];
    assign sel_db_s     = db_s[2];
    assign sel_db_nxt_s = db_s[2] ^ flip_s[2];

    // Mode state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r <= MODE_RUN;
        end else begin
            mode_r <= mode_nxt_s;
        end
    end

    // Next mode: adjust switch overrides the run flag from any state
    always_comb begin
        mode_nxt_s = MODE_RUN;
        case (mode_r)
            MODE_RUN, MODE_PAUSED, MODE_ADJ: begin
                if (adj_db_s) begin
                    mode_nxt_s = MODE_ADJ;
                end else if (run_flag_r) begin
                    mode_nxt_s = MODE_RUN;
                end else begin
                    mode_nxt_s = MODE_PAUSED;
                end
            end
            default: mode_nxt_s = MODE_RUN;
        endcase
    end

    // Run flag and blink phase next values; a pause landing with adjust entry is dropped
    always_comb begin
        run_flag_nxt_s = run_flag_r;
        blink_ph_nxt_s = blink_ph_r;
        if (pause_evt_s && (mode_r != MODE_ADJ) && !adj_db_nxt_s) begin
            run_flag_nxt_s = ~run_flag_r;
        end else begin
            run_flag_nxt_s = run_flag_r;
        end
        if ((mode_r != MODE_ADJ) && (mode_nxt_s == MODE_ADJ)) begin
            blink_ph_nxt_s = 1'b0;
        end else if ((mode_r == MODE_ADJ) && tick_2hz) begin
            blink_ph_nxt_s = ~blink_ph_r;
        end else begin
            blink_ph_nxt_s = blink_ph_r;
        end
    end

    // Strobes decode the pre-transition mode; rst_done_r masks a tick at reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done_r  <= 1'b0;
            run_flag_r  <= 1'b1;
            blink_ph_r  <= 1'b0;
            count_en_r  <= 1'b0;
            adj_sec_r   <= 1'b0;
            adj_min_r   <= 1'b0;
            blink_sec_r <= 1'b0;
            blink_min_r <= 1'b0;
        end else begin
            rst_done_r  <= 1'b1;
            run_flag_r  <= run_flag_nxt_s;
            blink_ph_r  <= blink_ph_nxt_s;
            count_en_r  <= rst_done_r & tick_1hz & (mode_r == MODE_RUN);
            adj_sec_r   <= rst_done_r & tick_2hz & (mode_r == MODE_ADJ) & sel_db_s;
            adj_min_r   <= rst_done_r & tick_2hz & (mode_r == MODE_ADJ) & ~sel_db_s;
            blink_sec_r <= blink_ph_nxt_s & (mode_nxt_s == MODE_ADJ) & sel_db_nxt_s;
            blink_min_r <= blink_ph_nxt_s & (mode_nxt_s == MODE_ADJ) & ~sel_db_nxt_s;
        end
    end

`ifdef LAP_EN
    logic lap_evt_s;
    logic freeze_r;

    assign lap_evt_s = flip_s[3] & ~db_s[3];

    // Lap press toggles the hold in RUN; leaving RUN always releases it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freeze_r <= 1'b0;
        end else if (mode_nxt_s != MODE_RUN) begin
            freeze_r <= 1'b0;
        end else if (lap_evt_s && (mode_r == MODE_RUN)) begin
            freeze_r <= ~freeze_r;
        end else begin
            freeze_r <= freeze_r;
        end
    end

    assign freeze = freeze_r;
`else
    assign freeze = 1'b0;
`endif

    assign count_en   = count_en_r;
    assign adj_sec_en = adj_sec_r;
    assign adj_min_en = adj_min_r;
    assign blink_sec  = blink_sec_r;
    assign blink_min  = blink_min_r;
    assign mode       = mode_r;

endmodule
